sub_countdown: RTL



---
 rtl/sub_countdown_pkg.sv | 18 +
 rtl/sub_countdown_if.sv | 25 ++
 rtl/sub_borrow_n.sv | 46 ++++
 rtl/sub_countdown.sv | 80 ++++++++
 4 files changed

// File: rtl/sub_countdown_pkg.sv
// sub_countdown_pkg: shared definitions for the countdown engine.
//   state_e       - FSM state encoding (IDLE/RUN/DONE)
//   DEFAULT_WIDTH - default count/step width
//   FA_LUT_INIT   - truth table of the 3-input XOR used as the adder sum LUT
package sub_countdown_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Sum LUT of one full adder: O = I0 ^ I1 ^ I2 (I3 tied low).
  localparam logic [15:0] FA_LUT_INIT = 16'h9696;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/sub_countdown_if.sv
// sub_countdown_if: control/status bundle of the countdown engine.
//   master (driver side) : drives LOAD, LOAD_VAL, STEP, EN; sees COUNT, BUSY, DONE, UNDERFLOW
//   slave  (engine side) : the mirror image
interface sub_countdown_if #(
  parameter int WIDTH = 4
);
  logic             LOAD;
  logic [WIDTH-1:0] LOAD_VAL;
  logic [WIDTH-1:0] STEP;
  logic             EN;
  logic [WIDTH-1:0] COUNT;
  logic             BUSY;
  logic             DONE;
  logic             UNDERFLOW;

  modport master (
    output LOAD, LOAD_VAL, STEP, EN,
    input  COUNT, BUSY, DONE, UNDERFLOW
  );

  modport slave (
    input  LOAD, LOAD_VAL, STEP, EN,
    output COUNT, BUSY, DONE, UNDERFLOW
  );
endinterface

// File: rtl/sub_borrow_n.sv
// sub_borrow_n: WIDTH-bit ripple subtractor O = A - B, built as A + ~B + 1.
//   A, B  in  WIDTH  minuend / subtrahend
//   O     out WIDTH  difference (mod 2^WIDTH)
//   COUT  out 1      carry out of the MSB adder; inverted borrow (1 = no borrow)
// sub_borrow_fa: one bit of the chain, a LUT4 sum plus a dedicated carry cell.

module sub_borrow_fa
  import sub_countdown_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic [15:0] lut;
  assign lut = FA_LUT_INIT;
  // LUT4 addressed as {I3,I2,I1,I0} = {0,ci,b,a}
  assign s  = lut[{1'b0, ci, b, a}];
  // carry cell: majority of the two operands and carry-in
  assign co = (a & b) | ((a | b) & ci);
endmodule

module sub_borrow_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] O,
  output logic             COUT
);
  logic [WIDTH-1:0] b_n;
  logic [WIDTH:0]   carry;

  assign b_n      = ~B;
  assign carry[0] = 1'b1;   // the +1 of two's-complement negation
  assign COUT     = carry[WIDTH];

  sub_borrow_fa u_fa [WIDTH-1:0] (
    .a  (A),
    .b  (b_n),
    .ci (carry[WIDTH-1:0]),
    .s  (O),
    .co (carry[WIDTH:1])
  );
endmodule

// File: rtl/sub_countdown.sv
// sub_countdown: load-and-decrement countdown engine.
//   CLK    in  rising-edge clock
//   RESET  in  synchronous active-high reset (overrides LOAD)
//   bus    slave modport of sub_countdown_if:
//          LOAD/LOAD_VAL start a count, STEP is subtracted on each EN cycle in RUN,
//          COUNT/BUSY/DONE/UNDERFLOW are all registered.
// The subtractor always computes COUNT - STEP; the FSM decides whether to use it.
module sub_countdown
  import sub_countdown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic         CLK,
  input  logic         RESET,
  sub_countdown_if.slave bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             underflow_q, underflow_d;
  logic             busy_q, done_q;

  logic [WIDTH-1:0] diff;
  logic             cout;
  logic             borrow;
  logic             diff_zero;

  sub_borrow_n #(.WIDTH(WIDTH)) u_sub (
    .A    (count_q),
    .B    (bus.STEP),
    .O    (diff),
    .COUT (cout)
  );

  assign borrow    = ~cout;
  assign diff_zero = ~|diff;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    underflow_d = underflow_q;
    if (bus.LOAD) begin
      // restart from any state; an in-flight decrement is dropped
      count_d     = bus.LOAD_VAL;
      underflow_d = 1'b0;
      state_d     = (bus.LOAD_VAL == '0) ? DONE : RUN;
    end else if (state_q == RUN && bus.EN) begin
      if (borrow) begin
        count_d     = '0;
        underflow_d = 1'b1;
        state_d     = DONE;
      end else begin
        // STEP==0 lands here with diff==COUNT (nonzero in RUN), so it just holds
        count_d = diff;
        if (diff_zero) state_d = DONE;
      end
    end
  end

  // Status flags are registered off the next state so they line up with COUNT.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      count_q     <= '0;
      underflow_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
      busy_q      <= (state_d == RUN);
      done_q      <= (state_d == DONE);
    end
  end

  assign bus.COUNT     = count_q;
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.UNDERFLOW = underflow_q;
endmodule
